// File: rtl/ifmap_pkg.sv
// Shared types and parameter defaults for the ifmap ping-pong buffer.
package ifmap_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_READY   = 2'd2
  } bank_state_e;

  localparam int MAX_LINES_DEF = 35;
  localparam int MAX_ELEMS_DEF = 256;
  localparam int PKT_ELEMS_DEF = 8;
  localparam int DATA_W_DEF    = 8;

  // An overlap that would swallow the whole batch is meaningless; treat it as none.
  function automatic int eff_overlap(input int ov, input int lines);
    return (ov >= lines) ? 0 : ov;
  endfunction

endpackage

// File: rtl/ifmap_pingpong_buffer_pkt_compact.sv
// pkt_compact: packs the valid lanes of a packet into the low positions, in
// ascending lane order, and reports how many lanes were valid.
module pkt_compact
  import ifmap_pkg::*;
#(
  parameter int PKT_ELEMS = PKT_ELEMS_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic [PKT_ELEMS-1:0]           mask_i,
  input  logic [PKT_ELEMS*DATA_W-1:0]    data_i,
  output logic [PKT_ELEMS*DATA_W-1:0]    data_o,
  output logic [$clog2(PKT_ELEMS+1)-1:0] cnt_o
);

  localparam int CW = $clog2(PKT_ELEMS+1);

  int pos;

  // Walk the lanes once, appending each valid one at the next free slot
  always_comb begin
    data_o = '0;
    pos    = 0;
    for (int i = 0; i < PKT_ELEMS; i++) begin
      if (mask_i[i]) begin
        data_o[pos*DATA_W +: DATA_W] = data_i[i*DATA_W +: DATA_W];
        pos = pos + 1;
      end
    end
    cnt_o = CW'(pos);
  end

endmodule

// File: rtl/ifmap_pingpong_buffer.sv
// ifmap_pingpong_buffer: two-bank row buffer for input feature maps. One bank
// fills from the packet stream while the other is presented to the consumer.
// Optional feature: define IFMAP_PP_OVERLAP_EN to carry the last cfg_overlap
// rows of the previous batch into the top of the next one.
//
// Bank states:
//   state        | meaning
//   BANK_EMPTY   | free, waiting to be picked for filling
//   BANK_FILLING | receiving packets at the (row, col) write pointer
//   BANK_READY   | complete batch, queued for the consumer
//
// out_data layout: element (row r, col c) sits at bits
// [(r*MAX_ELEMS + c)*DATA_W +: DATA_W].
module ifmap_pingpong_buffer
  import ifmap_pkg::*;
#(
  parameter int MAX_LINES = MAX_LINES_DEF,
  parameter int MAX_ELEMS = MAX_ELEMS_DEF,
  parameter int PKT_ELEMS = PKT_ELEMS_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [$clog2(MAX_LINES+1)-1:0]       cfg_lines,
  input  logic [$clog2(MAX_ELEMS+1)-1:0]       cfg_elems,
  input  logic [$clog2(MAX_LINES+1)-1:0]       cfg_overlap,
  input  logic [7:0]                           cfg_batches,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [PKT_ELEMS-1:0]                 in_mask,
  input  logic [PKT_ELEMS*DATA_W-1:0]          in_data,
  input  logic                                 free,
  output logic [MAX_LINES*MAX_ELEMS*DATA_W-1:0] out_data,
  output logic                                 out_valid,
  output logic                                 out_bank,
  output logic                                 done
);

  localparam int LW     = $clog2(MAX_LINES+1);
  localparam int EW     = $clog2(MAX_ELEMS+1);
  localparam int CW     = $clog2(PKT_ELEMS+1);
  localparam int ROW_W  = MAX_ELEMS*DATA_W;
  localparam int BANK_W = MAX_LINES*ROW_W;

  bank_state_e       st_q [2];
  bank_state_e       st_d [2];
  logic [BANK_W-1:0] mem_q [2];
  logic [BANK_W-1:0] mem_d [2];
  logic [LW-1:0]     row_q, row_d;
  logic [EW-1:0]     col_q, col_d;
  logic [7:0]        loaded_q, loaded_d;
  logic              fill_bank_q, fill_bank_d;
  logic              oldest_q, oldest_d;
  logic              started_q, started_d;
  logic [LW-1:0]     lines_q, lines_d;
  logic [EW-1:0]     elems_q, elems_d;
  logic [7:0]        batches_q, batches_d;
`ifdef IFMAP_PP_OVERLAP_EN
  logic [LW-1:0]     overlap_q, overlap_d;
  logic              last_bank_q, last_bank_d;
  int                ov_c;
`else
  logic              unused_cfg_overlap;
  assign unused_cfg_overlap = ^cfg_overlap;
`endif

  logic [PKT_ELEMS*DATA_W-1:0] comp_data;
  logic [CW-1:0]               comp_cnt;
  logic                        filling_any, rdy0, rdy1, pres_bank;
  logic                        fill_start, xfer, free_fire;
  logic                        nb_c, other_c;
  int                          wr_r, wr_c;

  pkt_compact #(
    .PKT_ELEMS (PKT_ELEMS),
    .DATA_W    (DATA_W)
  ) u_compact (
    .mask_i (in_mask),
    .data_i (in_data),
    .data_o (comp_data),
    .cnt_o  (comp_cnt)
  );

  assign filling_any = (st_q[0] == BANK_FILLING) || (st_q[1] == BANK_FILLING);
  assign rdy0        = (st_q[0] == BANK_READY);
  assign rdy1        = (st_q[1] == BANK_READY);
  // With both banks READY the older one goes first; otherwise the only READY one.
  assign pres_bank   = (rdy0 && rdy1) ? oldest_q : rdy1;

  assign out_valid = rdy0 || rdy1;
  assign out_bank  = pres_bank;
  assign out_data  = out_valid ? mem_q[pres_bank] : '0;
  assign in_ready  = started_q && filling_any && (loaded_q < batches_q) &&
                     (lines_q != '0) && (elems_q != '0);
  assign done      = started_q && (loaded_q == batches_q) &&
                     (st_q[0] == BANK_EMPTY) && (st_q[1] == BANK_EMPTY);

  assign xfer      = in_valid && in_ready;
  assign free_fire = free && out_valid;
  // A new fill is only opened while more batches are still owed, so the
  // buffer can drain to done once the last batch has been consumed.
  assign fill_start = started_q && !filling_any && (loaded_q < batches_q) &&
                      ((st_q[0] == BANK_EMPTY) || (st_q[1] == BANK_EMPTY));

  // Next state: start wins; otherwise open a fill, write a packet, complete, release
  always_comb begin
    st_d        = st_q;
    mem_d       = mem_q;
    row_d       = row_q;
    col_d       = col_q;
    loaded_d    = loaded_q;
    fill_bank_d = fill_bank_q;
    oldest_d    = oldest_q;
    started_d   = started_q;
    lines_d     = lines_q;
    elems_d     = elems_q;
    batches_d   = batches_q;
`ifdef IFMAP_PP_OVERLAP_EN
    overlap_d   = overlap_q;
    last_bank_d = last_bank_q;
    ov_c        = 0;
`endif
    wr_r    = int'(row_q);
    wr_c    = int'(col_q);
    nb_c    = (st_q[0] == BANK_EMPTY) ? 1'b0 : 1'b1;
    other_c = ~fill_bank_q;

    if (start) begin
      st_d[0]     = BANK_EMPTY;
      st_d[1]     = BANK_EMPTY;
      mem_d[0]    = '0;
      mem_d[1]    = '0;
      row_d       = '0;
      col_d       = '0;
      loaded_d    = '0;
      fill_bank_d = 1'b0;
      oldest_d    = 1'b0;
      started_d   = 1'b1;
      lines_d     = cfg_lines;
      elems_d     = cfg_elems;
      batches_d   = cfg_batches;
`ifdef IFMAP_PP_OVERLAP_EN
      overlap_d   = cfg_overlap;
      last_bank_d = 1'b0;
`endif
    end else begin
      if (fill_start) begin
        st_d[nb_c]  = BANK_FILLING;
        fill_bank_d = nb_c;
        row_d       = '0;
        col_d       = '0;
`ifdef IFMAP_PP_OVERLAP_EN
        if (loaded_q != '0) begin
          ov_c = eff_overlap(int'(overlap_q), int'(lines_q));
          for (int rr = 0; rr < MAX_LINES; rr++) begin
            if (rr < ov_c) begin
              mem_d[nb_c][rr*ROW_W +: ROW_W] =
                mem_q[last_bank_q][(int'(lines_q) - ov_c + rr)*ROW_W +: ROW_W];
            end
          end
          row_d = LW'(ov_c);
        end
`endif
      end

      if (xfer) begin
        for (int k = 0; k < PKT_ELEMS; k++) begin
          if ((k < int'(comp_cnt)) && (wr_r < int'(lines_q))) begin
            mem_d[fill_bank_q][(wr_r*MAX_ELEMS + wr_c)*DATA_W +: DATA_W] =
              comp_data[k*DATA_W +: DATA_W];
            wr_c = wr_c + 1;
            if (wr_c == int'(elems_q)) begin
              wr_c = 0;
              wr_r = wr_r + 1;
            end
          end
        end
        row_d = LW'(wr_r);
        col_d = EW'(wr_c);
        if (wr_r == int'(lines_q)) begin
          st_d[fill_bank_q] = BANK_READY;
          loaded_d          = loaded_q + 8'd1;
`ifdef IFMAP_PP_OVERLAP_EN
          last_bank_d       = fill_bank_q;
`endif
          // The other bank stays ahead in line only if it is READY and not leaving now
          if ((st_q[other_c] == BANK_READY) && !(free_fire && (pres_bank == other_c)))
            oldest_d = other_c;
          else
            oldest_d = fill_bank_q;
        end
      end

      if (free_fire) st_d[pres_bank] = BANK_EMPTY;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]     <= BANK_EMPTY;
      st_q[1]     <= BANK_EMPTY;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      loaded_q    <= '0;
      fill_bank_q <= 1'b0;
      oldest_q    <= 1'b0;
      started_q   <= 1'b0;
      lines_q     <= '0;
      elems_q     <= '0;
      batches_q   <= '0;
`ifdef IFMAP_PP_OVERLAP_EN
      overlap_q   <= '0;
      last_bank_q <= 1'b0;
`endif
    end else begin
      st_q[0]     <= st_d[0];
      st_q[1]     <= st_d[1];
      mem_q[0]    <= mem_d[0];
      mem_q[1]    <= mem_d[1];
      row_q       <= row_d;
      col_q       <= col_d;
      loaded_q    <= loaded_d;
      fill_bank_q <= fill_bank_d;
      oldest_q    <= oldest_d;
      started_q   <= started_d;
      lines_q     <= lines_d;
      elems_q     <= elems_d;
      batches_q   <= batches_d;
`ifdef IFMAP_PP_OVERLAP_EN
      overlap_q   <= overlap_d;
      last_bank_q <= last_bank_d;
`endif
    end
  end

endmodule

// File: tb/tb_ifmap_pingpong_buffer.sv
// Testbench for ifmap_pingpong_buffer. Follows IFMAP_PP_OVERLAP_EN when defined.
module tb_ifmap_pingpong_buffer;

  localparam int ML = 6;
  localparam int ME = 12;
  localparam int PK = 8;
  localparam int DW = 8;
  localparam int LW = $clog2(ML+1);
  localparam int EW = $clog2(ME+1);
  localparam int BW = ML*ME*DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [LW-1:0]   cfg_lines;
  logic [EW-1:0]   cfg_elems;
  logic [LW-1:0]   cfg_overlap;
  logic [7:0]      cfg_batches;
  logic            in_valid;
  logic            in_ready;
  logic [PK-1:0]   in_mask;
  logic [PK*DW-1:0] in_data;
  logic            free;
  logic [BW-1:0]   out_data;
  logic            out_valid;
  logic            out_bank;
  logic            done;

  always #5 clk = ~clk;

  ifmap_pingpong_buffer #(
    .MAX_LINES (ML),
    .MAX_ELEMS (ME),
    .PKT_ELEMS (PK),
    .DATA_W    (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_lines   (cfg_lines),
    .cfg_elems   (cfg_elems),
    .cfg_overlap (cfg_overlap),
    .cfg_batches (cfg_batches),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mask     (in_mask),
    .in_data     (in_data),
    .free        (free),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_bank    (out_bank),
    .done        (done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bank contents as a 2-D array, a FIFO of ready banks
  // (oldest first) and a flat fill position within the current bank.
  int         m_state [2];   // 0 empty, 1 filling, 2 ready
  logic [7:0] m_mem [2][ML][ME];
  int         rq[$];
  int         m_fill, m_pos, m_loaded, m_last, m_started;
  int         c_lines, c_elems, c_ov, c_batches;

  task automatic model_clear();
    for (int b = 0; b < 2; b++) begin
      m_state[b] = 0;
      for (int r = 0; r < ML; r++)
        for (int c = 0; c < ME; c++) m_mem[b][r][c] = 8'h00;
    end
    rq.delete();
    m_fill = -1; m_pos = 0; m_loaded = 0; m_last = 0;
  endtask

  function automatic int exp_ready();
    return int'(m_started != 0 && m_fill >= 0 && m_loaded < c_batches &&
                c_lines > 0 && c_elems > 0);
  endfunction

  function automatic int exp_done();
    return int'(m_started != 0 && m_loaded == c_batches &&
                m_state[0] == 0 && m_state[1] == 0);
  endfunction

  function automatic logic [BW-1:0] exp_data();
    logic [BW-1:0] v = '0;
    if (rq.size() > 0)
      for (int r = 0; r < ML; r++)
        for (int c = 0; c < ME; c++) v[(r*ME+c)*DW +: DW] = m_mem[rq[0]][r][c];
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    int  fb, ov;
    bit  xfer, do_free;
    if (start) begin
      model_clear();
      c_lines = int'(cfg_lines); c_elems = int'(cfg_elems);
      c_ov = int'(cfg_overlap); c_batches = int'(cfg_batches);
      m_started = 1;
      return;
    end
    xfer    = in_valid && (exp_ready() != 0);
    do_free = free && (rq.size() > 0);
    if (m_fill < 0 && m_started != 0 && m_loaded < c_batches &&
        (m_state[0] == 0 || m_state[1] == 0)) begin
      fb = (m_state[0] == 0) ? 0 : 1;
      m_state[fb] = 1;
      m_fill = fb;
      m_pos = 0;
`ifdef IFMAP_PP_OVERLAP_EN
      if (m_loaded > 0) begin
        ov = (c_ov >= c_lines) ? 0 : c_ov;
        for (int r = 0; r < ov; r++)
          for (int c = 0; c < ME; c++) m_mem[fb][r][c] = m_mem[m_last][c_lines-ov+r][c];
        m_pos = ov * c_elems;
      end
`endif
    end
    if (xfer) begin
      for (int i = 0; i < PK; i++) begin
        if (in_mask[i] && m_pos < c_lines*c_elems) begin
          m_mem[m_fill][m_pos / c_elems][m_pos % c_elems] = in_data[i*DW +: DW];
          m_pos++;
        end
      end
      if (m_pos == c_lines*c_elems) begin
        m_state[m_fill] = 2;
        rq.push_back(m_fill);
        m_loaded++;
        m_last = m_fill;
        m_fill = -1;
      end
    end
    if (do_free) begin
      fb = rq.pop_front();
      m_state[fb] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready",  BW'(in_ready),  BW'(exp_ready()));
    chk("out_valid", BW'(out_valid), BW'(rq.size() > 0));
    chk("out_bank",  BW'(out_bank),  BW'((rq.size() > 0) ? rq[0] : 0));
    chk("done",      BW'(done),      BW'(exp_done()));
    chk("out_data",  out_data,       exp_data());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_start(input int l, input int e, input int o, input int b);
    cfg_lines = LW'(l); cfg_elems = EW'(e); cfg_overlap = LW'(o); cfg_batches = 8'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (exp_ready() == 0 && k < 10) begin
      tick();
      k++;
    end
    if (exp_ready() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: in_ready not expected within 10 cycles", tag);
    end
  endtask

  task automatic send(input logic [PK-1:0] m, input logic [PK*DW-1:0] d);
    in_valid = 1'b1; in_mask = m; in_data = d;
    tick();
    in_valid = 1'b0; in_mask = '0;
  endtask

  function automatic logic [PK*DW-1:0] seq_pkt(input int base);
    logic [PK*DW-1:0] p;
    for (int i = 0; i < PK; i++) p[i*DW +: DW] = 8'(base + i);
    return p;
  endfunction

  function automatic logic [7:0] elem(input int r, input int c);
    return out_data[(r*ME+c)*DW +: DW];
  endfunction

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; cfg_lines = '0; cfg_elems = '0; cfg_overlap = '0;
    cfg_batches = '0; in_valid = 1'b0; in_mask = '0; in_data = '0; free = 1'b0;
    model_clear();
    m_started = 0; c_lines = 0; c_elems = 0; c_ov = 0; c_batches = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    tick();
    tick();

    // Layout: 3 rows x 10 elements, four full packets, last two elements dropped
    do_start(3, 10, 0, 1);
    wait_ready("layout_ready");
    for (int p = 0; p < 4; p++) send(8'hFF, seq_pkt(p*8 + 1));
    chk("layout_valid", BW'(out_valid), BW'(1));
    chk("layout_bank",  BW'(out_bank),  BW'(0));
    chk("layout_r0c0",  BW'(elem(0, 0)), BW'(8'd1));
    chk("layout_r1c0",  BW'(elem(1, 0)), BW'(8'd11));
    chk("layout_r2c9",  BW'(elem(2, 9)), BW'(8'd30));
    free = 1'b1;
    tick();
    free = 1'b0;
    chk("layout_done", BW'(done), BW'(1));

    // Compaction: mask 0xA5 over lanes 1..8, then one element lands at column 4
    do_start(2, 10, 0, 1);
    wait_ready("compact_ready");
    send(8'hA5, seq_pkt(1));
    send(8'h01, seq_pkt(8'h55));
    send(8'hFF, seq_pkt(8'h60));
    send(8'hFF, seq_pkt(8'h68));
    chk("compact_c0", BW'(elem(0, 0)), BW'(8'd1));
    chk("compact_c1", BW'(elem(0, 1)), BW'(8'd3));
    chk("compact_c2", BW'(elem(0, 2)), BW'(8'd6));
    chk("compact_c3", BW'(elem(0, 3)), BW'(8'd8));
    chk("compact_c4", BW'(elem(0, 4)), BW'(8'h55));
    chk("compact_r1c9", BW'(elem(1, 9)), BW'(8'h6E));
    free = 1'b1;
    tick();
    free = 1'b0;

    // Ping-pong: three batches, no free until both banks are READY
    do_start(2, 4, 0, 3);
    wait_ready("pp_ready0");
    send(8'hFF, seq_pkt($urandom_range(0, 200)));
    wait_ready("pp_ready1");
    send(8'hFF, seq_pkt($urandom_range(0, 200)));
    tick();
    chk("pp_stall_ready", BW'(in_ready), BW'(0));
    chk("pp_stall_bank",  BW'(out_bank), BW'(0));
    free = 1'b1;
    tick();
    free = 1'b0;
    chk("pp_after_free_bank", BW'(out_bank), BW'(1));
    wait_ready("pp_refill");
    send(8'hFF, seq_pkt($urandom_range(0, 200)));
    chk("pp_oldest_bank", BW'(out_bank), BW'(1));
    free = 1'b1;
    tick();
    tick();
    free = 1'b0;
    chk("pp_done", BW'(done), BW'(1));

    // Free coincident with the completing transfer
    do_start(1, 8, 0, 2);
    wait_ready("coinc_ready0");
    send(8'hFF, seq_pkt(8'h20));
    wait_ready("coinc_ready1");
    in_valid = 1'b1; in_mask = 8'hFF; in_data = seq_pkt(8'h30); free = 1'b1;
    tick();
    in_valid = 1'b0; in_mask = '0; free = 1'b0;
    chk("coinc_valid", BW'(out_valid), BW'(1));
    chk("coinc_bank",  BW'(out_bank),  BW'(1));
    free = 1'b1;
    tick();
    free = 1'b0;
    chk("coinc_done", BW'(done), BW'(1));

    // Start mid-fill discards everything
    do_start(1, 8, 0, 3);
    wait_ready("mid_ready0");
    send(8'hFF, seq_pkt(8'h10));
    wait_ready("mid_ready1");
    send(8'h0F, seq_pkt(8'h18));
    do_start(1, 8, 0, 3);
    chk("mid_start_valid", BW'(out_valid), BW'(0));
    chk("mid_start_ready", BW'(in_ready),  BW'(0));
    chk("mid_start_data",  out_data,       BW'(0));
    tick();

    // Overlap: 5 rows x 4 elements, overlap 2
    do_start(5, 4, 2, 2);
    wait_ready("ov_ready0");
    for (int p = 0; p < 3; p++) send(8'hFF, seq_pkt(8'h40 + p*8));
    wait_ready("ov_ready1");
    free = 1'b1;
    send(8'h01, seq_pkt(8'hA0));
    free = 1'b0;
    k = 0;
    while (m_loaded < 2 && k < 10) begin
      send(8'hFF, seq_pkt(8'hB0 + k*8));
      k++;
    end
    chk("ov_bank", BW'(out_bank), BW'(1));
`ifdef IFMAP_PP_OVERLAP_EN
    chk("ov_r0c0", BW'(elem(0, 0)), BW'(8'h4C));
    chk("ov_r1c3", BW'(elem(1, 3)), BW'(8'h53));
    chk("ov_r2c0", BW'(elem(2, 0)), BW'(8'hA0));
`else
    chk("ov_r0c0", BW'(elem(0, 0)), BW'(8'hA0));
`endif

    // Randomized rounds against the model
    for (int rnd = 0; rnd < 6; rnd++) begin
      do_start($urandom_range(0, ML), $urandom_range(0, ME),
               $urandom_range(0, ML), $urandom_range(0, 4));
      for (int cyc = 0; cyc < 200; cyc++) begin
        in_valid = 1'($urandom_range(0, 1));
        in_mask  = PK'($urandom);
        in_data  = {$urandom, $urandom};
        free     = ($urandom_range(0, 3) == 0);
        tick();
      end
      in_valid = 1'b0; free = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifmap_pingpong_buffer.md
IFMAP_PINGPONG_BUFFER -- requirements
Module: ifmap_pingpong_buffer

Interface
REQ-001 SHALL have parameter MAX_LINES, default 35: maximum rows per bank.
REQ-002 SHALL have parameter MAX_ELEMS, default 256: maximum elements per row.
REQ-003 SHALL have parameter PKT_ELEMS, default 8: element lanes per input packet.
REQ-004 SHALL have parameter DATA_W, default 8: bits per element.
REQ-005 SHALL have port clk, input, 1: clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: synchronous clear and configuration latch.
REQ-008 SHALL have port cfg_lines, input, $clog2(MAX_LINES+1): rows per batch, sampled on start.
REQ-009 SHALL have port cfg_elems, input, $clog2(MAX_ELEMS+1): elements per row, sampled on start.
REQ-010 SHALL have port cfg_overlap, input, $clog2(MAX_LINES+1): rows carried into the next batch, sampled on start.
REQ-011 SHALL have port cfg_batches, input, 8: batches to load before input stops, sampled on start.
REQ-012 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_mask (input, PKT_ELEMS) and in_data (input, PKT_ELEMS*DATA_W): packet stream, with lane i valid when in_mask[i]=1.
REQ-013 SHALL have port free, input, 1: controller releases the bank currently presented.
REQ-014 SHALL have ports out_data (output, MAX_LINES*MAX_ELEMS*DATA_W), out_valid (output, 1), out_bank (output, 1) and done (output, 1).

Function
REQ-015 SHALL hold two banks, each in state EMPTY, FILLING or READY.
REQ-016 Only one bank SHALL be FILLING at a time; an EMPTY bank SHALL become FILLING the cycle after no bank is FILLING, with bank 0 chosen on a tie.
REQ-017 A transfer SHALL occur when in_valid=1 and in_ready=1; in_ready SHALL be 1 only while a bank is FILLING and the loaded count is below cfg_batches.
REQ-018 Each transfer SHALL write valid lanes compacted in ascending lane order, starting at the current (row, column) write pointer; invalid lanes SHALL NOT consume positions.
REQ-019 Elements reaching column cfg_elems SHALL wrap to column 0 of the next row in the same cycle; elements beyond the last row SHALL be discarded.
REQ-020 A bank SHALL become READY in the cycle after the transfer that fills row cfg_lines-1, column cfg_elems-1; the loaded count SHALL then increment.
REQ-021 out_valid SHALL be 1 while any bank is READY; out_bank and out_data SHALL present the oldest READY bank; out_data SHALL be 0 when out_valid=0.
REQ-022 free with out_valid=1 SHALL set the presented bank to EMPTY the next cycle; free with out_valid=0 SHALL be ignored.
REQ-023 Simultaneous free and fill-complete SHALL both take effect in the same cycle.
REQ-024 done SHALL be 1 when the loaded count equals cfg_batches and both banks are EMPTY.
REQ-025 cfg_overlap >= cfg_lines SHALL be treated as 0; cfg_lines=0 or cfg_elems=0 SHALL hold in_ready at 0.
REQ-026 start asserted mid-operation SHALL discard all contents, set both banks to EMPTY, zero the pointers and counters, and take priority over all other events.

Reset
REQ-027 Reset SHALL give: banks EMPTY, contents 0, pointers 0, loaded count 0, in_ready=0, out_valid=0, out_bank=0, out_data=0, done=0, configuration 0.

Configuration
REQ-028 With IFMAP_PP_OVERLAP_EN defined, on EMPTY->FILLING after at least one batch has completed, rows 0..ov-1 SHALL copy the last ov rows of the most recently completed bank in that cycle, and the row pointer SHALL start at ov (ov = effective cfg_overlap).
REQ-029 Without IFMAP_PP_OVERLAP_EN, cfg_overlap SHALL be ignored and every fill SHALL start at row 0.

Structure
REQ-030 Package ifmap_pkg SHALL hold the bank-state enum and the parameter defaults.
REQ-031 Sub-module pkt_compact SHALL produce compacted lanes and the popcount from in_mask.

Verification
REQ-032 Layout: cfg_lines=3, cfg_elems=10, mask 0xFF x4 -> rows 0 and 1 full, row 2 holds 10 elements, bank 0 READY, and the 2 excess elements are dropped.
REQ-033 Compaction: mask 0xA5, data lanes 0..7 = 1..8 -> columns 0..3 = 1,3,6,8; column pointer = 4.
REQ-034 Ping-pong: cfg_batches=3, no free -> bank 1 fills after bank 0, in_ready drops with both banks READY, free -> bank 0 refills.
REQ-035 Overlap (macro on): cfg_lines=5, cfg_overlap=2 -> batch 2 rows 0-1 equal batch 1 rows 3-4 and writing starts at row 2; macro off -> writing starts at row 0.
REQ-036 Events: free coincident with final transfer -> both take effect; start mid-fill -> all EMPTY next cycle; done=1 after the last free.
